// File: rtl/phys_reg_free_list_if.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list_if
//   Rename-stage bus of the physical register free list.
//   master : rename/dispatch/commit logic (drives requests, commits, flush)
//   slave  : the free list (answers with grants, occupancy and error flag)
//
//   alloc_req        lane k needs a destination this cycle
//   alloc_ready      all requesting lanes can be served and no flush is active
//   alloc_preg       physical index granted to lane k
//   commit_valid     committing instruction k returns an old mapping
//   commit_old_preg  previous mapping of that destination
//   flush            discard every uncommitted allocation
//   free_count       number of free entries
//   dup_err          sticky duplicate-free error (FREE_LIST_DUP_CHECK_EN only)
// -----------------------------------------------------------------------------
interface phys_reg_free_list_if #(
  parameter int SS = 2,
  parameter int PW = 6,
  parameter int CW = 6
);
  logic [SS-1:0]         alloc_req;
  logic                  alloc_ready;
  logic [SS-1:0][PW-1:0] alloc_preg;
  logic [SS-1:0]         commit_valid;
  logic [SS-1:0][PW-1:0] commit_old_preg;
  logic                  flush;
  logic [CW-1:0]         free_count;
  logic                  dup_err;

  modport master (
    output alloc_req, commit_valid, commit_old_preg, flush,
    input  alloc_ready, alloc_preg, free_count, dup_err
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_preg, flush,
    output alloc_ready, alloc_preg, free_count, dup_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
//   Circular free list of physical register indices. Hands out up to SS free
//   destinations per cycle (all-or-nothing, lane-compacted), takes back the
//   previous mapping of each committing destination at the tail, and tracks a
//   retire head so a flush returns every speculative allocation in one cycle.
//
//   Ports
//     clk  clock
//     rst  synchronous active-high reset; restores pointers and storage
//     bus  phys_reg_free_list_if.slave (see the interface for signal list)
//
//   Optional feature (macro FREE_LIST_DUP_CHECK_EN)
//     Keeps an in_list bit per physical register. Commits of index 0 or of an
//     index that is already free are dropped and raise the sticky dup_err.
//     Without the macro dup_err is tied low and commits are unchecked.
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
  parameter int SS            = 2,
  parameter int TABLE_ENTRIES = 64,
  parameter int ARCH_REGS     = 32
) (
  input  logic                clk,
  input  logic                rst,
  phys_reg_free_list_if.slave bus
);
  localparam int DEPTH = TABLE_ENTRIES - ARCH_REGS;
  localparam int PW    = $clog2(TABLE_ENTRIES);
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;

  // Pointer = {wrap bit, index}; index runs modulo DEPTH.
  typedef logic [CW-1:0] ptr_t;
  typedef logic [PW-1:0] preg_t;

  // p + n with n <= DEPTH, so at most one wrap of the index.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n);
    logic [CW:0] sum;
    ptr_t        r;
    sum = {2'b00, p[IW-1:0]} + {1'b0, n};
    r   = p;
    if (sum >= (CW+1)'(DEPTH)) begin
      r[IW-1:0] = IW'(sum - (CW+1)'(DEPTH));
      r[CW-1]   = ~p[CW-1];
    end else begin
      r[IW-1:0] = sum[IW-1:0];
    end
    return r;
  endfunction

  // Distance a - b, valid while a is at most DEPTH entries ahead of b.
  function automatic ptr_t ptr_sub(input ptr_t a, input ptr_t b);
    ptr_t ai;
    ptr_t bi;
    ai = ptr_t'(a[IW-1:0]);
    bi = ptr_t'(b[IW-1:0]);
    return (a[CW-1] == b[CW-1]) ? ai - bi : ptr_t'(DEPTH) + ai - bi;
  endfunction

  ptr_t          head, tail, retire_head;
  ptr_t          head_d, tail_d, retire_head_d;
  preg_t         storage [DEPTH];
  ptr_t          req_cnt, com_cnt, free_cnt;
  logic          fire;
  logic [SS-1:0] commit_ok;
  logic [IW-1:0] alloc_slot  [SS];
  logic [IW-1:0] commit_slot [SS];

  // Allocation: lane k reads head + (requesting lanes below k).
  always_comb begin
    ptr_t off;
    ptr_t p;
    // NOTE: every variable gets a value before any branch, so no latch can form.
    off = '0;
    p   = '0;
    for (int k = 0; k < SS; k++) begin
      p             = ptr_add(head, off);
      alloc_slot[k] = p[IW-1:0];
      if (bus.alloc_req[k]) off = off + ptr_t'(1);
    end
    req_cnt = off;
  end

  always_comb begin
    for (int k = 0; k < SS; k++) bus.alloc_preg[k] = storage[alloc_slot[k]];
  end

  assign free_cnt        = ptr_sub(tail, head);
  assign bus.free_count  = free_cnt;
  assign bus.alloc_ready = !bus.flush && (req_cnt <= free_cnt);
  assign fire            = bus.alloc_ready && (|bus.alloc_req);

  // Commit: accepted lanes write at tail + (accepted lanes below k).
  always_comb begin
    ptr_t off;
    ptr_t p;
    off = '0;
    p   = '0;
    for (int k = 0; k < SS; k++) begin
      p              = ptr_add(tail, off);
      commit_slot[k] = p[IW-1:0];
      if (commit_ok[k]) off = off + ptr_t'(1);
    end
    com_cnt = off;
  end

  // Flush lands on the retire head after this cycle's commits have moved it.
  assign tail_d        = ptr_add(tail, com_cnt);
  assign retire_head_d = ptr_add(retire_head, com_cnt);
  assign head_d        = bus.flush ? retire_head_d
                       : fire      ? ptr_add(head, req_cnt)
                       :             head;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [TABLE_ENTRIES-1:0] in_list, in_list_d;
  logic                     dup_q, dup_hit;

  // A lane is dropped if its index is 0, already free, or returned by an
  // earlier lane in the same cycle.
  always_comb begin
    logic [TABLE_ENTRIES-1:0] seen;
    seen      = in_list;
    commit_ok = '0;
    dup_hit   = 1'b0;
    for (int k = 0; k < SS; k++) begin
      if (bus.commit_valid[k]) begin
        if (seen[bus.commit_old_preg[k]] || bus.commit_old_preg[k] == '0) begin
          dup_hit = 1'b1;
        end else begin
          commit_ok[k]                 = 1'b1;
          seen[bus.commit_old_preg[k]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_t span;
    int   rel;
    in_list_d = in_list;
    span      = ptr_sub(head, retire_head_d);
    rel       = 0;
    if (fire) begin
      for (int k = 0; k < SS; k++)
        if (bus.alloc_req[k]) in_list_d[bus.alloc_preg[k]] = 1'b0;
    end
    for (int k = 0; k < SS; k++)
      if (commit_ok[k]) in_list_d[bus.commit_old_preg[k]] = 1'b1;
    // Entries in [retire_head, head) become free again on a flush.
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rel = i - int'(retire_head_d[IW-1:0]);
        if (rel < 0) rel = rel + DEPTH;
        if (rel < int'(span)) in_list_d[storage[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_list <= {{DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};
      dup_q   <= 1'b0;
    end else begin
      in_list <= in_list_d;
      dup_q   <= dup_q | dup_hit;
    end
  end

  assign bus.dup_err = dup_q;
`else
  assign commit_ok   = bus.commit_valid;
  assign bus.dup_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= {1'b1, {IW{1'b0}}};
      // NOTE: storage is reset because its initial contents are the free
      // registers ARCH_REGS..TABLE_ENTRIES-1, not don't-care data.
      for (int i = 0; i < DEPTH; i++) storage[i] <= preg_t'(ARCH_REGS + i);
    end else begin
      head        <= head_d;
      tail        <= tail_d;
      retire_head <= retire_head_d;
      for (int k = 0; k < SS; k++)
        if (commit_ok[k]) storage[commit_slot[k]] <= bus.commit_old_preg[k];
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// tb_phys_reg_free_list
//   Self-checking bench for phys_reg_free_list. A queue-based reference model
//   (free FIFO, in-flight allocations, pool of committable old mappings)
//   predicts every cycle; predictions go through a scoreboard queue and are
//   compared while the clock is low. A table of hand-derived vectors covers
//   the opening sequence; hand-written sequences cover empty, wrap, flush,
//   mid-run reset and the duplicate-free check.
// -----------------------------------------------------------------------------
module tb_phys_reg_free_list;
  localparam int SS    = 2;
  localparam int TE    = 64;
  localparam int AR    = 32;
  localparam int PW    = 6;
  localparam int CW    = 6;

  typedef struct {
    logic [1:0] req;
    logic [1:0] cv;
    int         p0;
    int         p1;
    logic       fl;
    logic       exp_ready;
    int         exp_fc;
    int         exp_p0;
    int         exp_p1;
  } vec_t;

  typedef struct {
    logic       ready;
    int         fc;
    logic       dup;
    logic [1:0] req;
    int         preg0;
    int         preg1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.SS(SS), .PW(PW), .CW(CW)) bus ();

  phys_reg_free_list #(
    .SS(SS), .TABLE_ENTRIES(TE), .ARCH_REGS(AR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   free_q[$];
  int   inflight[$];
  int   pool[$];
  logic dup_model;
  exp_t sb[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic in_free(input int p);
    foreach (free_q[i]) if (free_q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Pick a committable old mapping at random from the pool.
  function automatic int take();
    int idx;
    int v;
    idx = int'($urandom_range(0, pool.size() - 1));
    v   = pool[idx];
    pool.delete(idx);
    return v;
  endfunction

  task automatic model_reset();
    free_q.delete();
    inflight.delete();
    pool.delete();
    sb.delete();
    for (int i = AR; i < TE; i++) free_q.push_back(i);
    // 3, 4, 9, 5, 7 are committed explicitly by the hand-written sequences.
    for (int i = 1; i < AR; i++) if (!(i inside {3, 4, 5, 7, 9})) pool.push_back(i);
    dup_model = 1'b0;
  endtask

  task automatic drive_idle();
    bus.alloc_req       = '0;
    bus.commit_valid    = '0;
    bus.commit_old_preg = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus: predict, drive, compare, then advance the model.
  task automatic step(input logic [1:0] req, input logic [1:0] cv, input int p0,
                      input int p1, input logic fl, input string name);
    exp_t e;
    exp_t got;
    int   ci;
    int   cp [2];
    logic acc [2];
    @(negedge clk);
    bus.alloc_req          = req;
    bus.commit_valid       = cv;
    bus.commit_old_preg[0] = PW'(p0);
    bus.commit_old_preg[1] = PW'(p1);
    bus.flush              = fl;

    e.req   = req;
    e.fc    = free_q.size();
    e.dup   = dup_model;
    e.ready = !fl && ((int'(req[0]) + int'(req[1])) <= free_q.size());
    e.preg0 = 0;
    e.preg1 = 0;
    ci      = 0;
    if (req[0] && ci < free_q.size()) begin e.preg0 = free_q[ci]; ci++; end
    if (req[1] && ci < free_q.size()) begin e.preg1 = free_q[ci]; ci++; end
    sb.push_back(e);

    #2;
    got = sb.pop_front();
    check({name, " alloc_ready"}, 32'(bus.alloc_ready), 32'(got.ready));
    check({name, " free_count"}, 32'(bus.free_count), got.fc);
    check({name, " dup_err"}, 32'(bus.dup_err), 32'(got.dup));
    if (got.ready && got.req[0]) check({name, " preg lane0"}, 32'(bus.alloc_preg[0]), got.preg0);
    if (got.ready && got.req[1]) check({name, " preg lane1"}, 32'(bus.alloc_preg[1]), got.preg1);

    cp[0]  = p0;
    cp[1]  = p1;
    acc[0] = cv[0];
    acc[1] = cv[1];
`ifdef FREE_LIST_DUP_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      if (cv[k] && (cp[k] == 0 || in_free(cp[k]) || (k == 1 && acc[0] && cp[0] == cp[1]))) begin
        acc[k]    = 1'b0;
        dup_model = 1'b1;
      end
    end
`endif
    if (got.ready) begin
      for (int k = 0; k < 2; k++) if (req[k]) inflight.push_back(free_q.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        free_q.push_back(cp[k]);
        if (inflight.size() > 0) pool.push_back(inflight.pop_front());
      end
    end
    if (fl) begin
      free_q = {inflight, free_q};
      inflight.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nc;
    int         a;
    int         b;
    logic [1:0] rq;
    logic [1:0] cvv;
    logic       f;

    rst = 1'b1;
    drive_idle();

    //           req    cv     p0 p1 fl    ready fc  p0  p1
    vecs[0] = '{2'b11, 2'b00, 0, 0, 1'b0, 1'b1, 32, 32, 33};
    vecs[1] = '{2'b10, 2'b00, 0, 0, 1'b0, 1'b1, 30, -1, 34};
    vecs[2] = '{2'b01, 2'b00, 0, 0, 1'b0, 1'b1, 29, 35, -1};
    vecs[3] = '{2'b11, 2'b11, 3, 4, 1'b0, 1'b1, 28, 36, 37};
    vecs[4] = '{2'b11, 2'b01, 9, 0, 1'b1, 1'b0, 28, -1, -1};
    vecs[5] = '{2'b11, 2'b00, 0, 0, 1'b0, 1'b1, 32, 35, 36};
    vecs[6] = '{2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 30, -1, -1};

    do_reset();
    #2;
    check("reset free_count", 32'(bus.free_count), 32);
    check("reset alloc_ready", 32'(bus.alloc_ready), 1);
    check("reset dup_err", 32'(bus.dup_err), 0);

    // Opening sequence: first grants, lane compaction, commit, flush+commit.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].req, vecs[i].cv, vecs[i].p0, vecs[i].p1, vecs[i].fl, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table ready", i), 32'(bus.alloc_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d table free_count", i), 32'(bus.free_count), vecs[i].exp_fc);
      if (vecs[i].exp_p0 >= 0)
        check($sformatf("vec%0d table preg0", i), 32'(bus.alloc_preg[0]), vecs[i].exp_p0);
      if (vecs[i].exp_p1 >= 0)
        check($sformatf("vec%0d table preg1", i), 32'(bus.alloc_preg[1]), vecs[i].exp_p1);
    end

    // Drain to empty, then a single request must be refused.
    for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 0, 0, 1'b0, "drain");
    step(2'b01, 2'b00, 0, 0, 1'b0, "empty req");
    check("empty req ready", 32'(bus.alloc_ready), 0);
    check("empty req free_count", 32'(bus.free_count), 0);
    step(2'b00, 2'b00, 0, 0, 1'b0, "empty idle");
    check("empty idle ready", 32'(bus.alloc_ready), 1);
    check("empty idle free_count", 32'(bus.free_count), 0);

    // Walk the tail around so the {5,7} commit straddles index 31 -> 0.
    for (int i = 0; i < 14; i++) begin
      a = take();
      b = take();
      step((i == 0) ? 2'b00 : 2'b11, 2'b11, a, b, 1'b0, "wrap fill");
    end
    step(2'b11, 2'b11, 5, 7, 1'b0, "wrap commit");
    step(2'b01, 2'b00, 0, 0, 1'b0, "wrap alloc a");
    check("wrap free_count", 32'(bus.free_count), 2);
    check("wrap first grant", 32'(bus.alloc_preg[0]), 5);
    step(2'b01, 2'b00, 0, 0, 1'b0, "wrap alloc b");
    check("wrap second grant", 32'(bus.alloc_preg[0]), 7);

    // Random legal traffic including flushes.
    for (int n = 0; n < 300; n++) begin
      rq = 2'($urandom_range(0, 3));
      nc = int'($urandom_range(0, 2));
      if (nc > inflight.size()) nc = inflight.size();
      if (nc > pool.size()) nc = pool.size();
      a = 0;
      b = 0;
      case (nc)
        0: cvv = 2'b00;
        1: begin
          cvv = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
          if (cvv[0]) a = take();
          else        b = take();
        end
        default: begin
          cvv = 2'b11;
          a   = take();
          b   = take();
        end
      endcase
      f = ($urandom_range(0, 15) == 0);
      step(rq, cvv, a, b, f, "rand");
    end

    // Reset in the middle of traffic restores storage contents.
    do_reset();
    step(2'b11, 2'b00, 0, 0, 1'b0, "post reset");
    check("post reset preg0", 32'(bus.alloc_preg[0]), 32);
    check("post reset preg1", 32'(bus.alloc_preg[1]), 33);

    // Return 40 while it is still in the free list.
    step(2'b00, 2'b01, 40, 0, 1'b0, "dup commit");
    step(2'b00, 2'b00, 0, 0, 1'b0, "after dup");
`ifdef FREE_LIST_DUP_CHECK_EN
    check("dup flag set", 32'(bus.dup_err), 1);
    check("dup free_count", 32'(bus.free_count), 30);
`else
    check("dup flag clear", 32'(bus.dup_err), 0);
    check("dup free_count", 32'(bus.free_count), 31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
